// File: rtl/bfp_align_buffer.sv
// rtl/bfp_align_buffer.sv - ping-pong line store replaying bf16 lines as block-floating-point fixed point
module bfp_align_buffer #(
  parameter int LANES  = 8,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int FRAC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*16-1:0]       in_data,
  input  logic                      in_vld,
  input  logic [ADDR_W-1:0]         num_lines_minusone,
  input  logic [7:0]                max_exp,
  input  logic                      max_exp_vld,
  output logic [LANES*FRAC_W-1:0]   out_data,
  output logic [7:0]                out_exp,
  output logic                      out_vld,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      err_overflow,
  output logic                      err_count
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int LINE_W = LANES * 16;
  localparam int MAG_W  = FRAC_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic                      fill_sel_q, drain_sel_q;
  logic [CNT_W-1:0]          wr_cnt_q;
  logic [1:0]                bank_full_q, bank_full_d;
  logic [CNT_W-1:0]          bank_cnt_q [2];
  logic [7:0]                bank_exp_q [2];
  logic [CNT_W-1:0]          rd_ptr_q;
  logic                      rd_vld_q, rd_last_q;
  logic [LINE_W-1:0]         rd_data_q;
  logic [LINE_W-1:0]         mem_q [0:2*DEPTH-1];
  logic                      out_vld_q, out_last_q;
  logic [LANES*FRAC_W-1:0]   out_data_q;
  logic [7:0]                out_exp_q;
  logic                      err_overflow_q, err_count_q;

  logic                      wr_ok, close_ok, out_free, rd_en, done;
  logic [CNT_W-1:0]          close_cnt, exp_cnt, cur_cnt;
  logic [7:0]                cur_exp;
  logic [LANES*FRAC_W-1:0]   aligned;

  // Lanes past the representable shift or with a zero exponent flush to 0;
  // an exponent above the block exponent saturates the magnitude.
  function automatic logic [FRAC_W-1:0] align_lane(input logic [15:0] x, input logic [7:0] ex);
    logic [7:0]       e;
    logic [7:0]       d;
    logic [MAG_W-1:0] mag;
    logic [FRAC_W-1:0] r;
    e   = x[14:7];
    d   = ex - e;
    mag = {1'b1, x[6:0], {(FRAC_W-9){1'b0}}};
    if (e == 8'd0)
      mag = '0;
    else if (e > ex)
      mag = '1;
    else if (d >= 8'(MAG_W))
      mag = '0;
    else
      mag = mag >> d;
    r = {1'b0, mag};
    if (x[15])
      r = -r;
    return r;
  endfunction

  always_comb begin
    wr_ok       = in_vld && !bank_full_q[fill_sel_q] && (wr_cnt_q != DEPTH_C);
    close_cnt   = wr_cnt_q + CNT_W'(wr_ok);
    exp_cnt     = CNT_W'(num_lines_minusone) + CNT_W'(1);
    close_ok    = max_exp_vld && (close_cnt != '0);

    cur_cnt     = bank_cnt_q[drain_sel_q];
    cur_exp     = bank_exp_q[drain_sel_q];
    out_free    = !out_vld_q || out_ready;
    rd_en       = bank_full_q[drain_sel_q] && (rd_ptr_q < cur_cnt) && (!rd_vld_q || out_free);
    done        = (state_q == S_DRAIN) && out_vld_q && out_last_q && out_ready;

    bank_full_d = bank_full_q;
    if (done)
      bank_full_d[drain_sel_q] = 1'b0;
    if (close_ok)
      bank_full_d[fill_sel_q] = 1'b1;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bank_full_q[drain_sel_q]) state_d = S_DRAIN;
      S_DRAIN: if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    aligned = '0;
    for (int k = 0; k < LANES; k++)
      aligned[k*FRAC_W +: FRAC_W] = align_lane(rd_data_q[k*16 +: 16], cur_exp);
  end

  // Line storage is not reset; validity lives in bank_full_q and rd_vld_q.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem_q[{fill_sel_q, wr_cnt_q[ADDR_W-1:0]}] <= in_data;
    if (rd_en)
      rd_data_q <= mem_q[{drain_sel_q, rd_ptr_q[ADDR_W-1:0]}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      fill_sel_q     <= 1'b0;
      drain_sel_q    <= 1'b0;
      wr_cnt_q       <= '0;
      bank_full_q    <= '0;
      bank_cnt_q[0]  <= '0;
      bank_cnt_q[1]  <= '0;
      bank_exp_q[0]  <= '0;
      bank_exp_q[1]  <= '0;
      rd_ptr_q       <= '0;
      rd_vld_q       <= 1'b0;
      rd_last_q      <= 1'b0;
      out_vld_q      <= 1'b0;
      out_last_q     <= 1'b0;
      out_data_q     <= '0;
      out_exp_q      <= '0;
      err_overflow_q <= 1'b0;
      err_count_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_full_q <= bank_full_d;

      if (max_exp_vld)
        wr_cnt_q <= '0;
      else if (wr_ok)
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (close_ok) begin
        bank_cnt_q[fill_sel_q] <= close_cnt;
        bank_exp_q[fill_sel_q] <= max_exp;
        fill_sel_q             <= ~fill_sel_q;
      end
      if (in_vld && !wr_ok)
        err_overflow_q <= 1'b1;
      if (max_exp_vld && (close_cnt != exp_cnt))
        err_count_q <= 1'b1;

      if (done) begin
        drain_sel_q <= ~drain_sel_q;
        rd_ptr_q    <= '0;
      end else if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + CNT_W'(1);
      end

      // rd stage holds its line while the output register is stalled
      if (rd_en) begin
        rd_vld_q  <= 1'b1;
        rd_last_q <= (rd_ptr_q == cur_cnt - CNT_W'(1));
      end else if (out_free) begin
        rd_vld_q  <= 1'b0;
      end

      if (out_free) begin
        out_vld_q  <= rd_vld_q;
        out_last_q <= rd_vld_q && rd_last_q;
        if (rd_vld_q) begin
          out_data_q <= aligned;
          out_exp_q  <= cur_exp;
        end
      end
    end
  end

  assign out_data     = out_data_q;
  assign out_exp      = out_exp_q;
  assign out_vld      = out_vld_q;
  assign out_last     = out_last_q;
  assign err_overflow = err_overflow_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_bfp_align_buffer.sv
// tb/tb_bfp_align_buffer.sv - directed self-checking bench for bfp_align_buffer
module tb_bfp_align_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         in_vld;
  logic [10:0]  num_lines_minusone;
  logic [7:0]   max_exp;
  logic         max_exp_vld;
  logic [127:0] out_data;
  logic [7:0]   out_exp;
  logic         out_vld;
  logic         out_ready;
  logic         out_last;
  logic         err_overflow;
  logic         err_count;

  int checks = 0;
  int errors = 0;

  logic [127:0] got_data [$];
  logic         got_last [$];
  logic [7:0]   got_exp  [$];

  always #5 clk = ~clk;

  bfp_align_buffer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_data            (in_data),
    .in_vld             (in_vld),
    .num_lines_minusone (num_lines_minusone),
    .max_exp            (max_exp),
    .max_exp_vld        (max_exp_vld),
    .out_data           (out_data),
    .out_exp            (out_exp),
    .out_vld            (out_vld),
    .out_ready          (out_ready),
    .out_last           (out_last),
    .err_overflow       (err_overflow),
    .err_count          (err_count)
  );

  // Each handshake that completes at the next rising edge is recorded here.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      got_exp.push_back(out_exp);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] mk_line(input logic [15:0] l0, input logic [15:0] l7);
    return {l7, 96'h0, l0};
  endfunction

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_exp.delete();
  endtask

  task automatic send(input logic [127:0] line);
    in_data = line;
    in_vld  = 1'b1;
    @(posedge clk); #1;
    in_vld  = 1'b0;
  endtask

  task automatic close_node(input logic [7:0] e);
    max_exp     = e;
    max_exp_vld = 1'b1;
    @(posedge clk); #1;
    max_exp_vld = 1'b0;
  endtask

  task automatic wait_count(input int n, input int budget, output bit ok);
    int c = 0;
    while (got_data.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (got_data.size() >= n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_vld = 1'b0;
    max_exp_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_vld !== 1'b0) begin $display("FAIL reset_out_vld: got %b expected 0", out_vld); errors++; end
    checks++; if (out_data !== 128'h0) begin $display("FAIL reset_out_data: got %h expected 0", out_data); errors++; end
    checks++; if (out_exp !== 8'h0) begin $display("FAIL reset_out_exp: got %h expected 0", out_exp); errors++; end
    checks++; if (out_last !== 1'b0) begin $display("FAIL reset_out_last: got %b expected 0", out_last); errors++; end
    checks++; if ({err_overflow, err_count} !== 2'b00) begin $display("FAIL reset_errors: got %b expected 00", {err_overflow, err_count}); errors++; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_vld !== 1'b0) begin $display("FAIL reset_idle_vld: got %b expected 0", out_vld); errors++; end
  endtask

  task automatic test_basic();
    logic [15:0] in0 [4];
    logic [15:0] in7 [4];
    logic [15:0] e0  [4];
    logic [15:0] e7  [4];
    bit ok;
    in0 = '{16'h3F80, 16'hC000, 16'h0000, 16'h3200};
    in7 = '{16'h4000, 16'h3F00, 16'hBF80, 16'h4100};
    e0  = '{16'h2000, 16'hC000, 16'h0000, 16'h0000};
    e7  = '{16'h4000, 16'h1000, 16'hE000, 16'h7FFF};
    clear_q();
    num_lines_minusone = 11'd3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(mk_line(in0[i], in7[i]));
    close_node(8'd128);
    checks++; if (out_vld !== 1'b0) begin $display("FAIL basic_latency_t0: got %b expected 0", out_vld); errors++; end
    @(posedge clk); #1;
    checks++; if (out_vld !== 1'b0) begin $display("FAIL basic_latency_t1: got %b expected 0", out_vld); errors++; end
    @(posedge clk); #1;
    checks++; if (out_vld !== 1'b1) begin $display("FAIL basic_latency_t2: got %b expected 1", out_vld); errors++; end
    wait_count(4, 50, ok);
    checks++; if (!ok) begin $display("FAIL basic_timeout: got %0d lines expected 4", got_data.size()); errors++; end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i][15:0] !== e0[i]) begin $display("FAIL basic_lane0[%0d]: got %h expected %h", i, got_data[i][15:0], e0[i]); errors++; end
      checks++; if (got_data[i][127:112] !== e7[i]) begin $display("FAIL basic_lane7[%0d]: got %h expected %h", i, got_data[i][127:112], e7[i]); errors++; end
      checks++; if (got_exp[i] !== 8'd128) begin $display("FAIL basic_exp[%0d]: got %0d expected 128", i, got_exp[i]); errors++; end
      checks++; if (got_last[i] !== (i == 3)) begin $display("FAIL basic_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); errors++; end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_data.size() != 4) begin $display("FAIL basic_count: got %0d expected 4", got_data.size()); errors++; end
    checks++; if ({err_overflow, err_count} !== 2'b00) begin $display("FAIL basic_errors: got %b expected 00", {err_overflow, err_count}); errors++; end
  endtask

  task automatic test_backpressure();
    logic [15:0] e0 [4];
    bit ok;
    e0 = '{16'h2000, 16'hC000, 16'h0000, 16'h0000};
    clear_q();
    num_lines_minusone = 11'd3;
    out_ready = 1'b1;
    send(mk_line(16'h3F80, 16'h4000));
    send(mk_line(16'hC000, 16'h3F00));
    send(mk_line(16'h0000, 16'hBF80));
    send(mk_line(16'h3200, 16'h4100));
    close_node(8'd128);
    wait_count(2, 50, ok);
    out_ready = 1'b0;
    checks++; if (!ok) begin $display("FAIL bp_first_two: got %0d lines expected 2", got_data.size()); errors++; end
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_vld !== 1'b1 || out_data !== mk_line(16'h0000, 16'hE000) || out_last !== 1'b0) begin
        $display("FAIL bp_hold[%0d]: got vld=%b last=%b data=%h expected vld=1 last=0 data=%h", c, out_vld, out_last, out_data, mk_line(16'h0000, 16'hE000)); errors++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_count(4, 50, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_data.size() != 4) begin $display("FAIL bp_count: got %0d expected 4", got_data.size()); errors++; end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i][15:0] !== e0[i] || got_last[i] !== (i == 3)) begin
        $display("FAIL bp_line[%0d]: got %h last=%b expected %h last=%b", i, got_data[i][15:0], got_last[i], e0[i], (i == 3)); errors++;
      end
    end
  endtask

  task automatic test_ping_pong();
    logic [15:0] e0  [6];
    logic [7:0]  ee  [6];
    logic        el  [6];
    bit ok;
    e0 = '{16'h4000, 16'h2000, 16'h0001, 16'h0000, 16'h3000, 16'hD000};
    ee = '{8'd130, 8'd130, 8'd128, 8'd128, 8'd128, 8'd128};
    el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_q();
    out_ready = 1'b0;
    num_lines_minusone = 11'd1;
    send(mk_line(16'h4100, 16'h0000));
    send(mk_line(16'h4080, 16'h0000));
    close_node(8'd130);
    num_lines_minusone = 11'd3;
    send(mk_line(16'h3900, 16'h0000));
    send(mk_line(16'h3880, 16'h0000));
    send(mk_line(16'h3FC0, 16'h0000));
    send(mk_line(16'hBFC0, 16'h0000));
    close_node(8'd128);
    checks++; if (err_overflow !== 1'b0) begin $display("FAIL pp_no_overflow_yet: got %b expected 0", err_overflow); errors++; end
    send(mk_line(16'h3F80, 16'h3F80));
    send(mk_line(16'h3F80, 16'h3F80));
    checks++; if (err_overflow !== 1'b1) begin $display("FAIL pp_overflow: got %b expected 1", err_overflow); errors++; end
    out_ready = 1'b1;
    wait_count(6, 80, ok);
    repeat (8) @(posedge clk);
    #1;
    checks++; if (got_data.size() != 6) begin $display("FAIL pp_count: got %0d expected 6", got_data.size()); errors++; end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_data[i][15:0] !== e0[i] || got_exp[i] !== ee[i] || got_last[i] !== el[i]) begin
        $display("FAIL pp_line[%0d]: got %h exp=%0d last=%b expected %h exp=%0d last=%b", i, got_data[i][15:0], got_exp[i], got_last[i], e0[i], ee[i], el[i]); errors++;
      end
    end
    checks++; if (err_count !== 1'b0) begin $display("FAIL pp_err_count: got %b expected 0", err_count); errors++; end
  endtask

  task automatic test_count_mismatch();
    logic [15:0] e0 [3];
    bit ok;
    e0 = '{16'h2000, 16'h4000, 16'hC000};
    clear_q();
    out_ready = 1'b1;
    num_lines_minusone = 11'd3;
    send(mk_line(16'h3F80, 16'h0000));
    send(mk_line(16'h4000, 16'h0000));
    send(mk_line(16'hC000, 16'h0000));
    close_node(8'd128);
    checks++; if (err_count !== 1'b1) begin $display("FAIL cnt_err_count: got %b expected 1", err_count); errors++; end
    wait_count(3, 50, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_data.size() != 3) begin $display("FAIL cnt_count: got %0d expected 3", got_data.size()); errors++; end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_data[i][15:0] !== e0[i] || got_last[i] !== (i == 2)) begin
        $display("FAIL cnt_line[%0d]: got %h last=%b expected %h last=%b", i, got_data[i][15:0], got_last[i], e0[i], (i == 2)); errors++;
      end
    end
    checks++; if (err_overflow !== 1'b0) begin $display("FAIL cnt_overflow: got %b expected 0", err_overflow); errors++; end
  endtask

  task automatic test_coincident();
    logic [15:0] e0 [5];
    logic [7:0]  ee [5];
    logic        el [5];
    bit ok;
    e0 = '{16'h2000, 16'h2000, 16'h2000, 16'h4000, 16'hE000};
    ee = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd129};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    clear_q();
    out_ready = 1'b1;
    num_lines_minusone = 11'd3;
    for (int i = 0; i < 3; i++) send(mk_line(16'h3F80, 16'h0000));
    in_data = mk_line(16'h4000, 16'h0000);
    in_vld = 1'b1;
    max_exp = 8'd128;
    max_exp_vld = 1'b1;
    @(posedge clk); #1;
    max_exp_vld = 1'b0;
    in_data = mk_line(16'hC000, 16'h0000);
    @(posedge clk); #1;
    in_vld = 1'b0;
    num_lines_minusone = 11'd0;
    close_node(8'd129);
    wait_count(5, 60, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_data.size() != 5) begin $display("FAIL coin_count: got %0d expected 5", got_data.size()); errors++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (got_data[i][15:0] !== e0[i] || got_exp[i] !== ee[i] || got_last[i] !== el[i]) begin
        $display("FAIL coin_line[%0d]: got %h exp=%0d last=%b expected %h exp=%0d last=%b", i, got_data[i][15:0], got_exp[i], got_last[i], e0[i], ee[i], el[i]); errors++;
      end
    end
    checks++; if ({err_overflow, err_count} !== 2'b00) begin $display("FAIL coin_errors: got %b expected 00", {err_overflow, err_count}); errors++; end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    clear_q();
    out_ready = 1'b0;
    num_lines_minusone = 11'd3;
    for (int i = 0; i < 4; i++) send(mk_line(16'h3F80, 16'h3F80));
    close_node(8'd100);
    send(mk_line(16'h4000, 16'h4000));
    repeat (4) @(posedge clk);
    #1;
    checks++; if (out_vld !== 1'b1) begin $display("FAIL rmd_pre_vld: got %b expected 1", out_vld); errors++; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0 || out_last !== 1'b0) begin $display("FAIL rmd_async_clear: got vld=%b last=%b expected 0 0", out_vld, out_last); errors++; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if ({err_overflow, err_count} !== 2'b00) begin $display("FAIL rmd_errors: got %b expected 00", {err_overflow, err_count}); errors++; end
    clear_q();
    out_ready = 1'b1;
    num_lines_minusone = 11'd1;
    send(mk_line(16'h3F80, 16'h0000));
    send(mk_line(16'h4000, 16'h0000));
    close_node(8'd128);
    wait_count(2, 50, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (got_data.size() != 2) begin $display("FAIL rmd_count: got %0d expected 2", got_data.size()); errors++; end
    checks++; if (got_data[0][15:0] !== 16'h2000 || got_last[0] !== 1'b0) begin $display("FAIL rmd_line0: got %h last=%b expected 2000 last=0", got_data[0][15:0], got_last[0]); errors++; end
    checks++; if (got_data[1][15:0] !== 16'h4000 || got_last[1] !== 1'b1) begin $display("FAIL rmd_line1: got %h last=%b expected 4000 last=1", got_data[1][15:0], got_last[1]); errors++; end
    checks++; if ({err_overflow, err_count} !== 2'b00) begin $display("FAIL rmd_errors_after: got %b expected 00", {err_overflow, err_count}); errors++; end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0;
    in_vld = 1'b0;
    num_lines_minusone = '0;
    max_exp = '0;
    max_exp_vld = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    do_reset();
    test_backpressure();
    do_reset();
    test_ping_pong();
    do_reset();
    test_count_mismatch();
    do_reset();
    test_coincident();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
